// File: rtl/qspi_flash_sequencer.sv
// Frame-level QSPI command sequencer: opcode, 24-bit address, dummy and data bytes fed one at a time to a byte engine.
// Optional write-enable pre-frame when QSPI_SEQ_WREN_EN is defined.
module qspi_flash_sequencer #(
  parameter int         LEN_W       = 9,
  parameter logic [7:0] RD_OPCODE   = 8'h6B,
  parameter logic [7:0] PG_OPCODE   = 8'h32,
  parameter int         DUMMY_BYTES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             done,
  output logic             cs_hold,
  output logic [7:0]       eng_data,
  output logic             eng_rw,
  output logic [1:0]       eng_width,
  output logic             eng_valid,
  input  logic             eng_ready,
  input  logic [7:0]       eng_rdata,
  input  logic             eng_rvalid,
  output logic             eng_rready,
  output logic [2:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
  // the valid side holds its payload stable until that edge.

  localparam int CNT_W = (LEN_W < 2) ? 2 : LEN_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_DUMMY = 3'd3,
    S_DATA  = 3'd4,
`ifdef QSPI_SEQ_WREN_EN
    S_WREN  = 3'd6,
    S_GAP   = 3'd7,
`endif
    S_FIN   = 3'd5
  } state_t;

  state_t           state, state_next;
  state_t           post_addr, post_dummy;
  logic             op_q;
  logic [23:0]      addr_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] cnt;
  logic             issued;
  logic             issue_fire;
  logic             cpl_fire;

  // One byte outstanding: issued marks the window between engine accept and completion.
  assign issue_fire = eng_valid & eng_ready;
  assign cpl_fire   = issued & eng_rvalid & eng_rready;
  assign dbg_state  = state;

  assign post_dummy = (len_q == '0) ? S_FIN : S_DATA;
  assign post_addr  = (!op_q && DUMMY_BYTES > 0) ? S_DUMMY : post_dummy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= 1'b0;
      addr_q <= '0;
      len_q  <= '0;
      cnt    <= '0;
      issued <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && req_valid) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        len_q  <= req_len;
      end
      if (issue_fire) begin
        issued <= 1'b1;
      end else if (cpl_fire) begin
        issued <= 1'b0;
      end
      if (state_next != state) begin
        cnt <= '0;
      end else if (cpl_fire) begin
        cnt <= cnt + CNT_W'(1);
`ifdef QSPI_SEQ_WREN_EN
      end else if (state == S_GAP) begin
        cnt <= cnt + CNT_W'(1);
`endif
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
`ifdef QSPI_SEQ_WREN_EN
          state_next = req_op ? S_WREN : S_CMD;
`else
          state_next = S_CMD;
`endif
        end
      end
`ifdef QSPI_SEQ_WREN_EN
      S_WREN:  if (cpl_fire) state_next = S_GAP;
      S_GAP:   if (cnt == CNT_W'(1)) state_next = S_CMD;
`endif
      S_CMD:   if (cpl_fire) state_next = S_ADDR;
      S_ADDR:  if (cpl_fire && cnt == CNT_W'(2)) state_next = post_addr;
      S_DUMMY: if (cpl_fire && cnt == CNT_W'(DUMMY_BYTES - 1)) state_next = post_dummy;
      S_DATA:  if (cpl_fire && (cnt + CNT_W'(1)) == CNT_W'(len_q)) state_next = S_FIN;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    wr_ready   = 1'b0;
    rd_data    = 8'h00;
    rd_valid   = 1'b0;
    done       = 1'b0;
    cs_hold    = 1'b0;
    eng_data   = 8'h00;
    eng_rw     = 1'b0;
    eng_width  = 2'b00;
    eng_valid  = 1'b0;
    eng_rready = (state != S_IDLE);
    case (state)
      S_IDLE: req_ready = 1'b1;
`ifdef QSPI_SEQ_WREN_EN
      S_WREN: begin
        cs_hold   = 1'b1;
        eng_valid = !issued;
        eng_rw    = 1'b1;
        eng_data  = 8'h06;
      end
`endif
      S_CMD: begin
        cs_hold   = 1'b1;
        eng_valid = !issued;
        eng_rw    = 1'b1;
        eng_data  = op_q ? PG_OPCODE : RD_OPCODE;
      end
      S_ADDR: begin
        cs_hold   = 1'b1;
        eng_valid = !issued;
        eng_rw    = 1'b1;
        case (cnt[1:0])
          2'd0:    eng_data = addr_q[23:16];
          2'd1:    eng_data = addr_q[15:8];
          default: eng_data = addr_q[7:0];
        endcase
      end
      S_DUMMY: begin
        cs_hold   = 1'b1;
        eng_valid = !issued;
        eng_width = 2'b10;
      end
      S_DATA: begin
        cs_hold   = 1'b1;
        eng_width = 2'b10;
        if (op_q) begin
          eng_valid = wr_valid & !issued;
          eng_rw    = 1'b1;
          eng_data  = wr_data;
          wr_ready  = eng_ready & !issued;
        end else begin
          // Host backpressure flows straight through to the engine completion.
          eng_valid  = !issued;
          rd_data    = eng_rdata;
          rd_valid   = eng_rvalid;
          eng_rready = rd_ready;
        end
      end
      S_FIN: done = 1'b1;
      default: ;
    endcase
  end

endmodule
